// File: rtl/latch_write_arbiter.sv
// -----------------------------------------------------------------------------
// latch_write_arbiter
//
// Purpose:
//   Lets four requesters share one bank of level-sensitive D-latches. Each
//   write is a four-cycle sequence:
//     IDLE  - arbitrate, capture the winner's data
//     SETUP - present data with the enable low
//     OPEN  - make the latch transparent for one cycle
//     HOLD  - enable low again with the data steady, acknowledge the winner
//   Arbitration is round-robin. A 2-bit pointer gives the first requester to
//   look at, and the pointer moves past each winner once its write completes.
//
// Ports:
//   clk    in   system clock; all state changes on the rising edge
//   rst    in   asynchronous active-low reset
//   req    in   [3:0]         write requests, bit i = requester i
//   din    in   [4*WIDTH-1:0] requester data, din[i*WIDTH +: WIDTH] = requester i
//   grant  out  [3:0]         one-hot owner of the latch bank
//   ack    out  [3:0]         one-hot, single-cycle write-complete pulse
//   lat_d  out  [WIDTH-1:0]   data to the latch bank D inputs
//   lat_en out                latch bank enable, high = transparent
//   busy   out                high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module latch_write_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] din,
  output logic [3:0]         grant,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   lat_d,
  output logic               lat_en,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [1:0]         ptr_q,    ptr_d;     // round-robin start point
  logic [1:0]         win_q,    win_d;     // index of the current owner
  logic [3:0]         grant_q,  grant_d;
  logic [3:0]         ack_q,    ack_d;
  logic               lat_en_q, lat_en_d;
  logic               busy_q,   busy_d;
  logic [WIDTH-1:0]   lat_d_q,  lat_d_d;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  // Priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The loop runs from the
  // lowest priority up, so the highest-priority active request is the one
  // written last.
  // ---------------------------------------------------------------------------
  logic       arb_valid;
  logic [1:0] arb_idx;
  logic [1:0] cand;

  // NOTE: every variable written in an always_comb gets a default value first.
  // Any path that leaves a variable unassigned would infer a latch.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = ptr_q;
    cand      = ptr_q;
    for (int j = 3; j >= 0; j--) begin
      cand = ptr_q + 2'(j);
      if (req[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Data slice of the arbitration winner. It is captured only on the
  // IDLE->SETUP edge.
  logic [WIDTH-1:0] win_data;

  always_comb begin
    win_data = din[int'(arb_idx)*WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // Every output is computed one cycle ahead and then registered, so lat_en,
  // grant, ack and busy come straight from flops. This keeps the latch enable
  // free of glitches.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    grant_d  = grant_q;
    lat_d_d  = lat_d_q;
    busy_d   = busy_q;
    ack_d    = 4'b0000;   // single-cycle pulse unless explicitly set
    lat_en_d = 1'b0;      // high only while heading into OPEN

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = SETUP;
          win_d   = arb_idx;
          grant_d = 4'b0001 << arb_idx;
          lat_d_d = win_data;
          busy_d  = 1'b1;
        end
      end

      SETUP: begin
        state_d  = OPEN;
        lat_en_d = 1'b1;
      end

      OPEN: begin
        state_d = HOLD;
        ack_d   = grant_q;
      end

      HOLD: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        ptr_d   = win_q + 2'd1;   // wraps 3 -> 0 naturally
        // lat_d keeps its last value
      end

      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Single sequential block for the FSM and all of its registered outputs.
  // Asserting reset clears the enable immediately, with no clock edge needed,
  // and drops any transaction in progress without an ack.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs and the order of statements does not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      win_q    <= 2'd0;
      grant_q  <= 4'b0000;
      ack_q    <= 4'b0000;
      lat_en_q <= 1'b0;
      busy_q   <= 1'b0;
      lat_d_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      lat_en_q <= lat_en_d;
      busy_q   <= busy_d;
      lat_d_q  <= lat_d_d;
    end
  end

  // Outputs are the flops themselves, with no logic after them.
  assign grant  = grant_q;
  assign ack    = ack_q;
  assign lat_en = lat_en_q;
  assign busy   = busy_q;
  assign lat_d  = lat_d_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_latch_write_arbiter
//
// Directed bench for latch_write_arbiter. It includes a behavioural bank of
// active-low-reset D-latches driven by lat_d/lat_en. The clock period is
// 10 time units. Inputs change 1 unit after each rising edge, and outputs are
// sampled at that same point.
// -----------------------------------------------------------------------------
module tb_latch_write_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] din;
  logic [3:0]         grant;
  logic [3:0]         ack;
  logic [WIDTH-1:0]   lat_d;
  logic               lat_en;
  logic               busy;

  int tests_run    = 0;
  int tests_failed = 0;

  latch_write_arbiter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .din    (din),
    .grant  (grant),
    .ack    (ack),
    .lat_d  (lat_d),
    .lat_en (lat_en),
    .busy   (busy)
  );

  // Shared latch bank under control of the arbiter.
  logic [WIDTH-1:0] latch_q;
  always_latch begin
    if (!rst)        latch_q <= '0;
    else if (lat_en) latch_q <= lat_d;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;  // before any clock edge
    tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    tests_run++; if (lat_en !== 1'b0) begin tests_failed++; $display("FAIL reset_lat_en got=%b exp=0", lat_en); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (lat_d !== 8'h00) begin tests_failed++; $display("FAIL reset_lat_d got=%h exp=00", lat_d); end
    // Requests held off while reset is active.
    req = 4'b1111;
    din = 32'hDEAD_BEEF;
    tick();
    tick();
    tests_run++; if (busy !== 1'b0 || grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_held busy=%b grant=%b exp=0/0000", busy, grant); end
    req = 4'b0000;
    rst = 1'b1;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_idle busy=%b exp=0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  // Requester 2 alone; ptr = 0 beforehand, 3 afterwards.
  task automatic test_single();
    din = {8'h00, 8'hA5, 8'h00, 8'h00};
    req = 4'b0100;
    tick();  // SETUP
    req = 4'b0000;
    tests_run++; if (grant !== 4'b0100) begin tests_failed++; $display("FAIL single_setup_grant got=%b exp=0100", grant); end
    tests_run++; if (lat_en !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_setup_en_busy got=%b/%b exp=0/1", lat_en, busy); end
    tests_run++; if (lat_d !== 8'hA5) begin tests_failed++; $display("FAIL single_setup_lat_d got=%h exp=a5", lat_d); end
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL single_setup_ack got=%b exp=0000", ack); end
    tick();  // OPEN
    tests_run++; if (lat_en !== 1'b1 || ack !== 4'b0000) begin tests_failed++; $display("FAIL single_open en=%b ack=%b exp=1/0000", lat_en, ack); end
    tests_run++; if (lat_d !== 8'hA5 || grant !== 4'b0100) begin tests_failed++; $display("FAIL single_open_data lat_d=%h grant=%b exp=a5/0100", lat_d, grant); end
    tick();  // HOLD
    tests_run++; if (lat_en !== 1'b0 || ack !== 4'b0100) begin tests_failed++; $display("FAIL single_hold en=%b ack=%b exp=0/0100", lat_en, ack); end
    tests_run++; if (lat_d !== 8'hA5 || latch_q !== 8'hA5) begin tests_failed++; $display("FAIL single_hold_data lat_d=%h latch=%h exp=a5", lat_d, latch_q); end
    tick();  // IDLE
    tests_run++; if (busy !== 1'b0 || grant !== 4'b0000 || ack !== 4'b0000) begin tests_failed++; $display("FAIL single_idle busy=%b grant=%b ack=%b exp=0/0000/0000", busy, grant, ack); end
    tests_run++; if (lat_d !== 8'hA5) begin tests_failed++; $display("FAIL single_idle_lat_d got=%h exp=a5", lat_d); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_no_regrant busy=%b exp=0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  // One full transaction. Returns the grant seen in SETUP and the ack seen in
  // HOLD; req drops after the grant.
  task automatic run_txn(input logic [3:0] r, output logic [3:0] g, output logic [3:0] a);
    req = r;
    tick();
    g   = grant;
    req = 4'b0000;
    tick();
    tick();
    a   = ack;
    tick();
  endtask

  // ptr = 3 on entry.
  task automatic test_wrap();
    logic [3:0] g, a;
    din = {8'h3C, 8'h00, 8'h00, 8'hC3};
    run_txn(4'b1000, g, a);  // serves 3 -> ptr 0
    tests_run++; if (g !== 4'b1000 || a !== 4'b1000) begin tests_failed++; $display("FAIL wrap_serve3 grant=%b ack=%b exp=1000/1000", g, a); end
    run_txn(4'b1001, g, a);  // ptr 0 -> requester 0
    tests_run++; if (g !== 4'b0001 || a !== 4'b0001) begin tests_failed++; $display("FAIL wrap_ptr0 grant=%b ack=%b exp=0001/0001", g, a); end
    tests_run++; if (lat_d !== 8'hC3) begin tests_failed++; $display("FAIL wrap_ptr0_data got=%h exp=c3", lat_d); end
    run_txn(4'b1001, g, a);  // ptr 1 -> requester 3
    tests_run++; if (g !== 4'b1000 || a !== 4'b1000) begin tests_failed++; $display("FAIL wrap_ptr1 grant=%b ack=%b exp=1000/1000", g, a); end
    tests_run++; if (lat_d !== 8'h3C) begin tests_failed++; $display("FAIL wrap_ptr1_data got=%h exp=3c", lat_d); end
  endtask

  // ---------------------------------------------------------------------------
  // ptr = 0 on entry. All requests are held; the grant order is 0,1,2,3,0.
  task automatic test_back_to_back();
    logic [3:0]       exp_g [5];
    logic [WIDTH-1:0] exp_d [5];
    int n_pulse, n_ack, last_t;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    n_pulse = 0;
    n_ack   = 0;
    last_t  = 0;
    din = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int t = 1; t <= 20; t++) begin
      tick();
      tests_run++; if (!$onehot0(grant) || !$onehot0(ack)) begin tests_failed++; $display("FAIL b2b_onehot t=%0d grant=%b ack=%b", t, grant, ack); end
      if (lat_en === 1'b1) begin
        if (n_pulse < 5) begin
          tests_run++; if (grant !== exp_g[n_pulse] || lat_d !== exp_d[n_pulse]) begin tests_failed++; $display("FAIL b2b_pulse%0d grant=%b lat_d=%h exp=%b/%h", n_pulse, grant, lat_d, exp_g[n_pulse], exp_d[n_pulse]); end
        end
        if (n_pulse > 0) begin
          tests_run++; if (t - last_t != 4) begin tests_failed++; $display("FAIL b2b_spacing pulse%0d gap=%0d exp=4", n_pulse, t - last_t); end
        end
        last_t = t;
        n_pulse++;
      end
      if (ack !== 4'b0000) begin
        if (n_ack < 5) begin
          tests_run++; if (ack !== exp_g[n_ack] || latch_q !== exp_d[n_ack]) begin tests_failed++; $display("FAIL b2b_ack%0d ack=%b latch=%h exp=%b/%h", n_ack, ack, latch_q, exp_g[n_ack], exp_d[n_ack]); end
        end
        n_ack++;
      end
    end
    req = 4'b0000;
    tests_run++; if (n_pulse != 5 || n_ack != 5) begin tests_failed++; $display("FAIL b2b_count pulses=%0d acks=%0d exp=5/5", n_pulse, n_ack); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle busy=%b exp=0", busy); end
  endtask

  // ---------------------------------------------------------------------------
  // ptr = 1 on entry; requester 1 writes 5A while din and req change underneath.
  task automatic test_data_stability();
    din = {8'h00, 8'h00, 8'h5A, 8'h00};
    req = 4'b0010;
    tick();  // SETUP
    din = '1;
    req = 4'b0000;
    tests_run++; if (lat_d !== 8'h5A || grant !== 4'b0010) begin tests_failed++; $display("FAIL stab_setup lat_d=%h grant=%b exp=5a/0010", lat_d, grant); end
    tick();  // OPEN
    din = '0;
    tests_run++; if (lat_d !== 8'h5A || lat_en !== 1'b1) begin tests_failed++; $display("FAIL stab_open lat_d=%h en=%b exp=5a/1", lat_d, lat_en); end
    tick();  // HOLD
    tests_run++; if (ack !== 4'b0010 || lat_d !== 8'h5A) begin tests_failed++; $display("FAIL stab_hold ack=%b lat_d=%h exp=0010/5a", ack, lat_d); end
    tick();  // IDLE
    din = {8'hF0, 8'h0F, 8'hAA, 8'h55};
    tick();
    din = {8'h0F, 8'hF0, 8'h55, 8'hAA};
    tick();
    tests_run++; if (latch_q !== 8'h5A) begin tests_failed++; $display("FAIL stab_latch_hold latch=%h exp=5a", latch_q); end
  endtask

  // ---------------------------------------------------------------------------
  // ptr = 2 on entry; requester 0 is abandoned mid-OPEN.
  task automatic test_reset_mid_open();
    logic [3:0] g, a;
    din = {8'h00, 8'h00, 8'h77, 8'h99};
    req = 4'b0001;
    tick();  // SETUP
    req = 4'b0000;
    tick();  // OPEN
    tests_run++; if (lat_en !== 1'b1 || grant !== 4'b0001) begin tests_failed++; $display("FAIL rst_open_pre en=%b grant=%b exp=1/0001", lat_en, grant); end
    #2 rst = 1'b0;
    #1;      // still well before the next rising edge
    tests_run++; if (lat_en !== 1'b0 || grant !== 4'b0000) begin tests_failed++; $display("FAIL rst_async en=%b grant=%b exp=0/0000", lat_en, grant); end
    tests_run++; if (ack !== 4'b0000 || busy !== 1'b0 || lat_d !== 8'h00) begin tests_failed++; $display("FAIL rst_async2 ack=%b busy=%b lat_d=%h exp=0000/0/00", ack, busy, lat_d); end
    tests_run++; if (latch_q !== 8'h00) begin tests_failed++; $display("FAIL rst_latch latch=%h exp=00", latch_q); end
    tick();
    tests_run++; if (ack !== 4'b0000) begin tests_failed++; $display("FAIL rst_no_ack ack=%b exp=0000", ack); end
    rst = 1'b1;
    // ptr restarts at 0, so requester 1 beats requester 3.
    run_txn(4'b1010, g, a);
    tests_run++; if (g !== 4'b0010 || a !== 4'b0010) begin tests_failed++; $display("FAIL rst_ptr0 grant=%b ack=%b exp=0010/0010", g, a); end
    tests_run++; if (latch_q !== 8'h77) begin tests_failed++; $display("FAIL rst_resume_latch latch=%h exp=77", latch_q); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    req = 4'b0000;
    din = '0;
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_open();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
